latch6_arbiter: RTL and testbench
=================================

Name: latch6_arbiter

Overview:
- Round-robin arbiter and sequencer for the 6-bit enable-gated output latch.
- Shares the latch between NUM_REQ requesters, which are peripheral writers such as LED or seven-segment drivers.
- Captures the winning requester's data and drives it with the latch enable for a fixed hold window.
- Inserts a one-cycle blanking gap before the next grant.
- Sits between the peripheral write sources and the latch's data_i/en_i inputs.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
HOLD_CYCLES, 8, cycles en_o stays high per grant (>=1)
DATA_W, 6, latch data width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-high reset
req_i  input  NUM_REQ  per-requester request level
data_i  input  NUM_REQ*DATA_W  requester k data at bits [k*DATA_W +: DATA_W]
ack_o  output  NUM_REQ  one-hot, one-cycle pulse: request k accepted
grant_o  output  NUM_REQ  one-hot owner of the latch during HOLD, else 0
data_o  output  DATA_W  to latch data_i; captured winner data during HOLD, else 0
en_o  output  1  to latch en_i; high only in HOLD
busy_o  output  1  high in HOLD and GAP

Behaviour:
- Clock, reset and outputs:
  - Single clock domain.
  - rst_i=1 forces, asynchronously: state=IDLE, rr pointer=0, counter=0.
  - During reset, all outputs are 0 (ack_o, grant_o, data_o, en_o, busy_o).
  - Reset asserted mid-HOLD or mid-GAP aborts the grant immediately; no ack is reissued.
  - All outputs are registered; there are no combinational paths from req_i or data_i to outputs.
- FSM states: IDLE, HOLD, GAP.
- IDLE:
  - If req_i==0, remain in IDLE.
  - Otherwise, at the clock edge, select winner w = first set bit of req_i scanning upward from rr pointer, wrapping modulo NUM_REQ.
  - Also at that edge: data_o <= data_i[w]; grant_o <= onehot(w); ack_o <= onehot(w); en_o <= 1; busy_o <= 1.
  - Also at that edge: counter <= HOLD_CYCLES-1; rr pointer <= (w+1) mod NUM_REQ; go to HOLD.
- HOLD:
  - ack_o is high only in the first HOLD cycle.
  - en_o, grant_o and data_o are stable for exactly HOLD_CYCLES cycles.
  - data_i changes and req_i changes are ignored during HOLD.
  - Counter decrements each cycle. When counter==0, at the next edge go to GAP; en_o, grant_o and data_o clear to 0 and busy_o stays 1.
- GAP:
  - Exactly one cycle with en_o=0 and busy_o=1.
  - Next edge goes to IDLE and busy_o clears.
  - Requests are not sampled in GAP.
- Latency and throughput:
  - Request seen in IDLE at edge N: en_o high in cycles N+1 .. N+HOLD_CYCLES.
  - GAP at N+HOLD_CYCLES+1; IDLE at N+HOLD_CYCLES+2.
  - Maximum grant rate is one per HOLD_CYCLES+2 cycles.
- Handshake:
  - req_i is a level signal.
  - A requester must deassert req_i within HOLD_CYCLES cycles of ack_o.
  - A request still high when the arbiter returns to IDLE is treated as a new request.
- Fairness:
  - After a grant to w, w has lowest priority at the next arbitration.
  - Any continuously asserted requester is served within NUM_REQ grants.
- Wrap-around: winner NUM_REQ-1 sets rr pointer to 0.
- HOLD_CYCLES=1: a single HOLD cycle, in which ack_o and en_o are coincident.
- Invariants:
  - grant_o, ack_o: zero or one-hot.
  - en_o==1 implies grant_o!=0.
  - en_o==0 implies data_o==0.

Test Plan:
- Reset then idle: rst_i pulse, req_i=0 for 20 cycles -> all outputs 0, busy_o=0.
- Single request (NUM_REQ=4, HOLD_CYCLES=8):
  - Stimulus: req_i=4'b0100, data_i[2]=6'h2A, dropped after ack.
  - Required: ack_o=4'b0100 for 1 cycle, then en_o=1, data_o=6'h2A, grant_o=4'b0100 for exactly 8 cycles.
  - Then 1 GAP cycle with en_o=0 and busy_o=1, then IDLE.
- Round-robin, all four requesting continuously:
  - Stimulus: req_i=4'b1111, each re-asserting after its own ack.
  - Required: grant order 0,1,2,3,0.
  - Successive en_o rising edges are 10 cycles apart.
- Wrap priority:
  - Stimulus: grant to 3, then req_i=4'b1001 on return to IDLE.
  - Required: grant 0 next, then 3.
- Data/request changes during HOLD:
  - Stimulus: change data_i[w] and toggle other req_i bits mid-HOLD.
  - Required: data_o unchanged, grant_o unchanged, no extra ack_o.
- Reset mid-HOLD:
  - Stimulus: assert rst_i at hold cycle 4, asynchronously between edges.
  - Required: en_o, data_o, grant_o and busy_o drop to 0 without a clock edge.
  - After release with req_i=4'b0010, requester 1 wins (pointer back to 0).

Source files
------------

// File: rtl/latch6_arbiter.sv
// rtl/latch6_arbiter.sv - round-robin arbiter and sequencer for the 6-bit enable-gated output latch
//
// Shares the output latch between NUM_REQ peripheral writers. The winning requester's
// data is captured and held on data_o with en_o high for HOLD_CYCLES cycles. A single
// blanking cycle follows before the next arbitration.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset
//   req_i    in   [NUM_REQ]         per-requester request level
//   data_i   in   [NUM_REQ*DATA_W]  requester k data at [k*DATA_W +: DATA_W]
//   ack_o    out  [NUM_REQ]         one-cycle one-hot accept pulse
//   grant_o  out  [NUM_REQ]         one-hot latch owner during HOLD
//   data_o   out  [DATA_W]          captured winner data during HOLD, else 0
//   en_o     out                    latch enable, high only during HOLD
//   busy_o   out                    high during HOLD and GAP
module latch6_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int DATA_W      = 6
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*DATA_W-1:0] data_i,
   output logic [NUM_REQ-1:0]        ack_o,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic [DATA_W-1:0]         data_o,
   output logic                      en_o,
   output logic                      busy_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_GAP
   } state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     rr_q, rr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   ack_d, grant_d;
   logic [DATA_W-1:0]    data_d;
   logic                 en_d, busy_d;

   logic                 found;
   logic [PTR_W-1:0]     win;
   logic [PTR_W-1:0]     cand;
   logic [NUM_REQ-1:0]   win_oh;
   logic [DATA_W-1:0]    win_data;
   int                   idx;

   // Scan upward from the round-robin pointer, wrapping, and take the first set request.
   always_comb begin : arbitrate
      found    = 1'b0;
      win      = '0;
      cand     = '0;
      idx      = 0;
      win_oh   = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         cand = PTR_W'(idx);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      win_oh[win] = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (PTR_W'(k) == win) begin
            win_data = data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      ack_d   = '0;
      grant_d = grant_o;
      data_d  = data_o;
      en_d    = en_o;
      busy_d  = busy_o;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_HOLD;
               cnt_d   = CNT_W'(HOLD_CYCLES - 1);
               rr_d    = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
               ack_d   = win_oh;
               grant_d = win_oh;
               data_d  = win_data;
               en_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_HOLD: begin
            // The counter reaches zero in the last HOLD cycle; outputs drop at the
            // following edge while busy stays up through the blanking cycle.
            if (cnt_q == '0) begin
               state_d = S_GAP;
               grant_d = '0;
               data_d  = '0;
               en_d    = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            data_d  = '0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         cnt_q   <= '0;
         ack_o   <= '0;
         grant_o <= '0;
         data_o  <= '0;
         en_o    <= 1'b0;
         busy_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         ack_o   <= ack_d;
         grant_o <= grant_d;
         data_o  <= data_d;
         en_o    <= en_d;
         busy_o  <= busy_d;
      end
   end

endmodule

// File: tb/tb_latch6_arbiter.sv
// tb/tb_latch6_arbiter.sv - self-checking bench for latch6_arbiter
module tb_latch6_arbiter;

   localparam int NR = 4;
   localparam int H  = 8;
   localparam int DW = 6;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [NR-1:0] req_i;
   logic [NR*DW-1:0] data_i;
   logic [NR-1:0] ack_o, grant_o;
   logic [DW-1:0] data_o;
   logic          en_o, busy_o;

   latch6_arbiter #(.NUM_REQ(NR), .HOLD_CYCLES(H), .DATA_W(DW)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .data_i  (data_i),
      .ack_o   (ack_o),
      .grant_o (grant_o),
      .data_o  (data_o),
      .en_o    (en_o),
      .busy_o  (busy_o)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic chk_all(input string tag, input logic [3:0] ack, input logic [3:0] grant,
                          input logic [5:0] dout, input logic en, input logic busy);
      chk({tag, ".ack"},   32'(ack_o),   32'(ack));
      chk({tag, ".grant"}, 32'(grant_o), 32'(grant));
      chk({tag, ".data"},  32'(data_o),  32'(dout));
      chk({tag, ".en"},    32'(en_o),    32'(en));
      chk({tag, ".busy"},  32'(busy_o),  32'(busy));
   endtask

   // Reference model: a grant is a time window. The grant sampled at edge g_start is
   // visible for edges g_start..g_start+H-1, blanking follows at g_start+H, and the
   // next request can be sampled at g_start+H+2.
   int          e          = 0;
   int          g_start    = -1000;
   int          g_w        = 0;
   logic [5:0]  g_data     = '0;
   int          free_edge  = 0;
   int          m_rr       = 0;

   always @(posedge clk or posedge rst_i) begin
      int w;
      int cur;
      cur = e + 1;
      e <= cur;
      if (rst_i) begin
         g_start   <= -1000;
         free_edge <= 0;
         m_rr      <= 0;
      end else if (cur >= free_edge && req_i != '0) begin
         w = -1;
         for (int i = 0; i < NR; i++) begin
            if (w < 0 && req_i[(m_rr + i) % NR]) w = (m_rr + i) % NR;
         end
         g_w       <= w;
         g_data    <= data_i[w*DW +: DW];
         g_start   <= cur;
         free_edge <= cur + H + 2;
         m_rr      <= (w + 1) % NR;
      end
   end

   task automatic chk_model(input string tag);
      logic in_hold;
      logic [3:0] oh;
      in_hold = (e >= g_start) && (e < g_start + H);
      oh = 4'(1 << g_w);
      chk_all(tag, (e == g_start) ? oh : 4'b0, in_hold ? oh : 4'b0,
              in_hold ? g_data : 6'h0, in_hold, (e >= g_start) && (e <= g_start + H));
   endtask

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [23:0] data;
      logic [3:0]  ack;
      logic [3:0]  grant;
      logic [5:0]  dout;
      logic        en;
      logic        busy;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rst, input logic [3:0] req, input logic [23:0] data,
                               input logic [3:0] ack, input logic [3:0] grant,
                               input logic [5:0] dout, input logic en, input logic busy);
      vec_t v;
      v.rst = rst; v.req = req; v.data = data; v.ack = ack; v.grant = grant;
      v.dout = dout; v.en = en; v.busy = busy;
      vecs.push_back(v);
   endfunction

   logic [3:0] gq[$];
   int         rq[$];

   // Record grant_o at each rising edge of en_o, for up to n grants or budget cycles.
   task automatic capture(input int n, input int budget);
      logic prev;
      gq.delete();
      rq.delete();
      prev = en_o;
      for (int c = 0; c < budget && gq.size() < n; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (en_o && !prev) begin
            gq.push_back(grant_o);
            rq.push_back(c);
         end
         prev = en_o;
      end
      chk("capture.count", 32'(gq.size()), 32'(n));
   endtask

   task automatic reset_pulse();
      rst_i = 1'b1;
      req_i = '0;
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [23:0] d;
      logic [3:0]  exp_rr[5];
      logic        done;
      d = {6'h15, 6'h2A, 6'h3F, 6'h01};
      rst_i  = 1'b1;
      req_i  = '0;
      data_i = '0;

      // Reset, idle, then a single request from requester 2 dropped after its ack.
      add(1'b1, 4'h0, 24'h0, 4'h0, 4'h0, 6'h0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) add(1'b0, 4'h0, 24'h0, 4'h0, 4'h0, 6'h0, 1'b0, 1'b0);
      add(1'b0, 4'b0100, d, 4'b0100, 4'b0100, 6'h2A, 1'b1, 1'b1);
      for (int i = 1; i < H; i++) add(1'b0, 4'h0, d, 4'h0, 4'b0100, 6'h2A, 1'b1, 1'b1);
      add(1'b0, 4'h0, d, 4'h0, 4'h0, 6'h0, 1'b0, 1'b1);
      add(1'b0, 4'h0, d, 4'h0, 4'h0, 6'h0, 1'b0, 1'b0);

      @(negedge clk);
      foreach (vecs[i]) begin
         rst_i  = vecs[i].rst;
         req_i  = vecs[i].req;
         data_i = vecs[i].data;
         @(posedge clk);
         @(negedge clk);
         chk_all($sformatf("vec%0d", i), vecs[i].ack, vecs[i].grant, vecs[i].dout,
                 vecs[i].en, vecs[i].busy);
      end

      // Round-robin with all four requesting continuously.
      reset_pulse();
      req_i  = 4'hF;
      data_i = d;
      capture(5, 60);
      exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < gq.size() && i < 5; i++) begin
         chk($sformatf("rr.grant%0d", i), 32'(gq[i]), 32'(exp_rr[i]));
         if (i > 0) chk($sformatf("rr.spacing%0d", i), 32'(rq[i] - rq[i-1]), 32'(H + 2));
      end

      // Wrap: grant to 3, then 4'b1001 on return to idle must go to 0 first.
      reset_pulse();
      req_i = 4'b1000;
      @(posedge clk);
      @(negedge clk);
      chk("wrap.first", 32'(grant_o), 32'(4'b1000));
      req_i = '0;
      done  = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(posedge clk);
         @(negedge clk);
         done = !busy_o;
      end
      chk("wrap.idle", 32'(done), 32'(1));
      req_i = 4'b1001;
      capture(2, 30);
      if (gq.size() > 0) chk("wrap.second", 32'(gq[0]), 32'(4'b0001));
      if (gq.size() > 1) chk("wrap.third",  32'(gq[1]), 32'(4'b1000));

      // Data and request changes during HOLD are ignored.
      reset_pulse();
      req_i  = 4'b0100;
      data_i = d;
      @(posedge clk);
      @(negedge clk);
      chk("hold.ack", 32'(ack_o), 32'(4'b0100));
      req_i = '0;
      for (int k = 2; k <= H; k++) begin
         if (k == 4) begin
            data_i = {6'h15, 6'h11, 6'h3F, 6'h01};
            req_i  = 4'b1011;
         end
         @(posedge clk);
         @(negedge clk);
         chk_all($sformatf("hold%0d", k), 4'h0, 4'b0100, 6'h2A, 1'b1, 1'b1);
      end
      @(posedge clk);
      @(negedge clk);
      chk_all("hold.gap", 4'h0, 4'h0, 6'h0, 1'b0, 1'b1);

      // Asynchronous reset in the fourth HOLD cycle, then pointer must be back at 0.
      reset_pulse();
      req_i  = 4'b0100;
      data_i = d;
      @(posedge clk);
      @(negedge clk);
      req_i = '0;
      for (int k = 2; k <= 4; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("rst.pre_en", 32'(en_o), 32'(1));
      #2 rst_i = 1'b1;
      #1 chk_all("rst.async", 4'h0, 4'h0, 6'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_i = 1'b0;
      req_i = 4'b1010;
      @(posedge clk);
      @(negedge clk);
      chk_all("rst.after", 4'b0010, 4'b0010, 6'h3F, 1'b1, 1'b1);

      // Randomized traffic against the reference model.
      reset_pulse();
      for (int c = 0; c < 400; c++) begin
         rst_i  = ($urandom_range(0, 99) == 0);
         req_i  = 4'($urandom) & 4'($urandom);
         data_i = 24'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk_model($sformatf("rand%0d", c));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
